alu_sequencer: RTL

Sequential controller on the initiator side of the ALU operand/opcode interface. It owns a 4-entry register file R0..R3, accepts one 8-bit instruction at a time over a valid/ready handshake, and drives the ALU opcode and operands. It writes the ALU result back to the register file and keeps a registered zero flag. It also drives a `data_out` port for store instructions.

---
 rtl/alu_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Initiator-side controller for a small combinational ALU. It holds a
// four-entry register file (R0..R3), accepts one 8-bit instruction at a time
// over a valid/ready handshake, drives the ALU opcode and operands for one
// EXEC cycle, and writes the ALU result back at the end of that cycle.
// Every instruction takes exactly three cycles: IDLE (accept), EXEC, WB.
//
// Instruction word: [7:5] op, [4:3] xx (dest / M1 select),
//                   [2:1] yy (M0 select), [0] reserved.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   instr             : instruction word, sampled only at the accept edge
//   instr_valid/ready : instruction handshake; ready only in IDLE
//   data_in           : operand for load, written directly (ALU bypassed)
//   alu_opcode        : ALU opcode, 000 outside EXEC and for load
//   alu_m1, alu_m0    : ALU operands, R[xx] / R[yy] in EXEC, 0 otherwise
//   alu_result        : ALU result, consumed at the edge ending EXEC
//   alu_zero          : ALU zero flag, consumed at the edge ending EXEC
//   data_out          : store data, held until the next store
//   data_out_valid    : one-cycle pulse in WB of a store
//   done              : one-cycle pulse in WB of every instruction
//   zero_flag         : registered status flag
//   dbg_sel, dbg_data : combinational register file read port
//
// State | Meaning
// ------+----------------------------------------------------------
// IDLE  | ready for an instruction; ALU inputs parked at zero
// EXEC  | ALU driven from latched instruction; write-back at exit edge
// WB    | done (and data_out_valid for store) pulse; ALU parked

module alu_sequencer #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_m1,
    output logic [DATA_W-1:0] alu_m0,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              done,
    output logic              zero_flag,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_DEC   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_ADD   = 3'b110;
    localparam logic [2:0] OP_COPY  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Only bits [7:1] of the instruction carry meaning.
    logic [6:0]        ir;
    logic              unused_instr_bit;

    logic [DATA_W-1:0] regs [4];

    logic [2:0]        ir_op;
    logic [1:0]        ir_xx;
    logic [1:0]        ir_yy;

    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              zf_upd;
    logic              store_cap;

    assign unused_instr_bit = instr[0];

    assign ir_op = ir[6:4];
    assign ir_xx = ir[3:2];
    assign ir_yy = ir[1:0];

    assign dbg_data = regs[dbg_sel];

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        // ready is gated by rst_n so it reads 0 for the whole reset window
        // and rises as soon as reset is released.
        instr_ready    = 1'b0;
        alu_opcode     = OP_NOP;
        alu_m1         = '0;
        alu_m0         = '0;
        done           = 1'b0;
        data_out_valid = 1'b0;

        unique case (state)
            IDLE: begin
                instr_ready = rst_n;
                if (instr_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                // Load bypasses the ALU, so the ALU sees a nop.
                alu_opcode = (ir_op == OP_LOAD) ? OP_NOP : ir_op;
                alu_m1     = regs[ir_xx];
                alu_m0     = regs[ir_yy];
                state_nxt  = WB;
            end
            WB: begin
                done           = 1'b1;
                data_out_valid = (ir_op == OP_STORE);
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write-back decode, evaluated in EXEC only
    // ------------------------------------------------------------------
    assign accept = (state == IDLE) && instr_valid;

    always_comb begin
        wr_en     = 1'b0;
        wr_data   = alu_result;
        zf_upd    = 1'b0;
        store_cap = 1'b0;

        if (state == EXEC) begin
            unique case (ir_op)
                OP_NOP: begin
                end
                OP_LOAD: begin
                    wr_en   = 1'b1;
                    wr_data = data_in;
                end
                OP_STORE: begin
                    zf_upd    = 1'b1;
                    store_cap = 1'b1;
                end
                OP_SET, OP_INC, OP_DEC, OP_ADD, OP_COPY: begin
                    wr_en  = 1'b1;
                    zf_upd = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (accept) begin
            ir <= instr[7:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[ir_xx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
        end else if (zf_upd) begin
            zero_flag <= alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (store_cap) begin
            data_out <= alu_result;
        end
    end

endmodule
